// File: rtl/inst_fetch_pkg.sv
// Shared widths, PC step and the prefetch entry layout for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential fetch step; wraps modulo 2^32 by construction.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory, redirect and decode-side handshake bundle of the fetch unit.
interface inst_fetch_if
  import inst_fetch_pkg::*;
();

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_en;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               align_err;

  // master = fetch unit, slave = memory/branch/decode environment
  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_en,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output align_err
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_en,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  align_err
  );

endinterface

// File: rtl/inst_fetch_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {instr, pc} with flush; head is read combinationally.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic do_push;
  logic do_pop;

  // A flush overrides both sides; the caller never pushes during a flush anyway.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, redirect handling and a small prefetch buffer toward decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  inst_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_p0;
  logic              align_err_p1;

  logic              push;
  logic              pop;
  logic              out_valid;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      fetch_word;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && bus.out_ready;
  // A full buffer still accepts a new word when decode frees the head this cycle.
  assign push      = !bus.redirect_en && ((fifo_count < CNT_W'(DEPTH)) || pop);

  assign fetch_word.instr = bus.imem_instr;
  assign fetch_word.pc    = pc_p0;

  // Stage p0: fetch PC, the only source of imem_addr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (bus.redirect_en) begin
      pc_p0 <= word_align(bus.redirect_addr);
    end else if (push) begin
      pc_p0 <= next_pc(pc_p0);
    end
  end

  // Stage p1: registered misalignment flag for the redirect just taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err_p1 <= 1'b0;
    end else begin
      align_err_p1 <= bus.redirect_en && is_misaligned(bus.redirect_addr);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_en),
    .push      (push),
    .pop       (pop),
    .push_data (fetch_word),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.imem_addr = pc_p0;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = fifo_head.instr;
  assign bus.out_pc    = fifo_head.pc;
  assign bus.align_err = align_err_p1;

endmodule
